// File: rtl/row_packer.sv
// Serial-to-packed row packer: gathers NUM_PE pixels per word, never lets a word straddle
// a row end, and presents each word as a single FIFO push behind a one-deep output register.
module row_packer_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,   // accepted pixel targets this lane
  input  logic                  keep,    // lane lies below the current lane of a completing word
  input  logic                  word_end,
  input  logic [DATA_WIDTH-1:0] pix,
  output logic [DATA_WIDTH-1:0] out_q
);
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] word_val;

  // Lanes above the completing pixel come out as zero, which pads a short row-end word.
  always_comb begin
    word_val = '0;
    if (wr_en)     word_val = pix;
    else if (keep) word_val = acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      if (word_end)   acc_q <= '0;
      else if (wr_en) acc_q <= pix;
      if (word_end)   out_q <= word_val;
    end
  end
endmodule

module row_packer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_PE       = 4,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         START,
  input  logic [DATA_WIDTH-1:0]        IN_DATA,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  output logic [NUM_PE*DATA_WIDTH-1:0] OUT_DATA,
  output logic                         OUT_PUSH,
  input  logic                         OUT_FULL,
  output logic                         BUSY,
  output logic                         DONE
);
  localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(NUM_PE - 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [LANE_W-1:0] lane;
  } pos_t;

  state_t state_q, state_d;
  pos_t   pos_q;
  logic   out_valid;
  logic   accept, row_end, word_done, frame_end;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0] out_lanes;

  assign row_end   = (pos_q.col == COL_MAX);
  assign accept    = IN_VALID && IN_READY;
  assign word_done = accept && ((pos_q.lane == LANE_MAX) || row_end);
  assign frame_end = accept && row_end && (pos_q.row == ROW_MAX);

  // A pixel may only land when its word is guaranteed a free output slot this edge.
  assign IN_READY = (state_q == RUN) && (!out_valid || !OUT_FULL);
  assign OUT_PUSH = out_valid && !OUT_FULL;
  assign BUSY     = (state_q != IDLE);
  assign OUT_DATA = out_lanes;

  always_comb begin
    state_d = state_q;
    DONE    = 1'b0;
    case (state_q)
      IDLE:  if (START) state_d = RUN;
      RUN:   if (frame_end) state_d = DRAIN;
      DRAIN: if (!out_valid) begin
        state_d = IDLE;
        DONE    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pos_q <= '0;
    end else if (accept) begin
      if (row_end) begin
        pos_q.lane <= '0;
        pos_q.col  <= '0;
        pos_q.row  <= (pos_q.row == ROW_MAX) ? '0 : pos_q.row + 1'b1;
      end else begin
        pos_q.lane <= (pos_q.lane == LANE_MAX) ? '0 : pos_q.lane + 1'b1;
        pos_q.col  <= pos_q.col + 1'b1;
      end
    end
  end

  // A completing word while the old one pushes reloads in place, keeping out_valid set.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)       out_valid <= 1'b0;
    else if (word_done) out_valid <= 1'b1;
    else if (OUT_PUSH)  out_valid <= 1'b0;
  end

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    row_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .wr_en    (accept && (pos_q.lane == LANE_W'(i))),
      .keep     (pos_q.lane > LANE_W'(i)),
      .word_end (word_done),
      .pix      (IN_DATA),
      .out_q    (out_lanes[i])
    );
  end
endmodule

// File: tb/tb_row_packer.sv
// Scoreboard bench for row_packer: the driver queues the expected words of each frame,
// and a negedge monitor pops and compares them on every push.
module tb_row_packer;
  logic        CLK = 1'b0;
  logic        RESET_N, START, IN_VALID, OUT_FULL;
  logic [7:0]  IN_DATA;
  logic [31:0] OUT_DATA;
  logic        IN_READY, OUT_PUSH, BUSY, DONE;

  row_packer #(.DATA_WIDTH(8), .NUM_PE(4), .IMAGE_WIDTH(10), .IMAGE_HEIGHT(10)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .OUT_DATA(OUT_DATA), .OUT_PUSH(OUT_PUSH), .OUT_FULL(OUT_FULL),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int          tests = 0, fails = 0;
  int          cyc = 0, last_push = -10, push_cnt = 0, done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] capture[30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every push must match the head of the expected queue.
  always @(negedge CLK) begin
    cyc++;
    if (OUT_PUSH) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_push actual=%h required=none t=%0t", OUT_DATA, $time);
      end else begin
        chk("push_word", OUT_DATA, exp_q.pop_front());
      end
      if (push_cnt < 30) capture[push_cnt] = OUT_DATA;
      push_cnt++;
      last_push = cyc;
    end
    if (DONE) begin
      done_cnt++;
      chk("done_after_last_push", cyc, last_push + 1);
      chk("done_queue_empty", exp_q.size(), 0);
    end
  end

  // Pixel (r,c) carries r*10+c+1; each row packs as cols 0-3, 4-7, 8-9 zero-padded.
  task automatic load_expected();
    for (int r = 0; r < 10; r++)
      for (int w = 0; w < 3; w++) begin
        logic [31:0] word = '0;
        for (int l = 0; l < 4; l++)
          if (w * 4 + l < 10) word[l*8 +: 8] = 8'(r * 10 + w * 4 + l + 1);
        exp_q.push_back(word);
      end
  endtask

  // Entered and left at posedge+1; returns once the pixel has been accepted.
  task automatic send_px(input logic [7:0] v, input int bubbles);
    int t = 0;
    IN_VALID = 1'b0;
    repeat (bubbles) begin @(posedge CLK); #1; end
    IN_VALID = 1'b1;
    IN_DATA  = v;
    forever begin
      #1;
      if (IN_READY) begin
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        return;
      end
      @(posedge CLK); #1;
      if (++t > 200) begin
        chk("accept_timeout", 32'(v), 32'hFFFF_FFFF);
        IN_VALID = 1'b0;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // mode: 0 nominal+latency, 1 backpressure, 2 random gaps, 3 START during RUN
  task automatic run_frame(input int mode);
    int base_done = done_cnt;
    int t = 0;
    push_cnt = 0;
    load_expected();
    pulse_start();
    chk("busy_after_start", BUSY, 1'b1);
    for (int p = 1; p <= 100; p++) begin
      send_px(8'(p), (mode == 2) ? $urandom_range(0, 3) : 0);
      if (mode == 0 && p == 4) begin
        #3;
        chk("latency_push", OUT_PUSH, 1'b1);
        chk("latency_word", OUT_DATA, 32'h04030201);
        @(posedge CLK); #1;
      end
      if (mode == 1 && p == 8) begin
        OUT_FULL = 1'b1;
        repeat (5) begin
          @(negedge CLK);
          chk("bp_in_ready", IN_READY, 1'b0);
          chk("bp_no_push", OUT_PUSH, 1'b0);
          chk("bp_data_stable", OUT_DATA, 32'h08070605);
        end
        @(posedge CLK); #1;
        OUT_FULL = 1'b0;
      end
      if (mode == 3 && p == 37) begin
        pulse_start();
        chk("busy_after_ignored_start", BUSY, 1'b1);
      end
    end
    while (done_cnt == base_done && t < 100) begin @(posedge CLK); t++; end
    repeat (3) @(posedge CLK);
    #1;
    chk("done_pulses", done_cnt - base_done, 1);
    chk("push_count", push_cnt, 30);
    chk("busy_after_done", BUSY, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, IN_READY, 1'b0);
    chk({tag, "_out_push"}, OUT_PUSH, 1'b0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_done"}, DONE, 1'b0);
    chk({tag, "_out_data"}, OUT_DATA, 32'h0);
  endtask

  initial begin
    void'($urandom(32'h5EED_0042));
    RESET_N = 1'b0; START = 1'b0; IN_VALID = 1'b0; OUT_FULL = 1'b0; IN_DATA = '0;
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(posedge CLK); #1;

    run_frame(0);
    chk("word0", capture[0], 32'h04030201);
    chk("word1", capture[1], 32'h08070605);
    chk("word2", capture[2], 32'h00000A09);
    chk("word3", capture[3], 32'h0E0D0C0B);
    chk("word4", capture[4], 32'h1211100F);
    chk("word5", capture[5], 32'h00001413);
    chk("word29", capture[29], 32'h00006463);

    run_frame(1);
    run_frame(2);
    run_frame(3);

    // Abort a frame after pixel 15; nothing from it may surface later.
    push_cnt = 0;
    load_expected();
    pulse_start();
    for (int p = 1; p <= 15; p++) send_px(8'(p), 0);
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    @(negedge CLK);
    check_reset_outputs("held_rst");
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA  = 8'hAA;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_wait_ready", IN_READY, 1'b0);
      chk("idle_wait_busy", BUSY, 1'b0);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    run_frame(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/row_packer.md
ROW_PACKER -- requirements
Module: row_packer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 8, pixel width.
- NUM_PE, 4, lanes per packed word.
- IMAGE_WIDTH, 10, pixels per row.
- IMAGE_HEIGHT, 10, rows per frame.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1, single clock, all state on rising edge.
- RESET_N, in, 1, asynchronous active-low reset.
- START, in, 1, frame start pulse.
- IN_DATA, in, DATA_WIDTH, serial pixel.
- IN_VALID, in, 1, pixel valid.
- IN_READY, out, 1, pixel accepted when IN_VALID&IN_READY.
- OUT_DATA, out, NUM_PE*DATA_WIDTH, packed word to input FIFO data_in.
- OUT_PUSH, out, 1, FIFO push.
- OUT_FULL, in, 1, FIFO full.
- BUSY, out, 1, frame in progress.
- DONE, out, 1, one-cycle frame-complete pulse.
REQ-003 The block has one clock (CLK); reset is asynchronous and active-low (RESET_N).

Function
REQ-004 The FSM has states IDLE, RUN, DRAIN; IDLE->RUN on START; RUN->DRAIN when the last pixel of the last row is accepted; DRAIN->IDLE when the output register is empty, with DONE=1 for exactly that cycle.
REQ-005 START outside IDLE is ignored.
REQ-006 BUSY is 1 in RUN and DRAIN and 0 in IDLE.
REQ-007 IN_READY = (state==RUN) && (!out_valid || !OUT_FULL); out_valid is the output-register occupancy flag.
REQ-008 Counters: lane 0..NUM_PE-1, col 0..IMAGE_WIDTH-1, row 0..IMAGE_HEIGHT-1.
- All counters advance only on accepted pixels.
- lane wraps to 0 at NUM_PE-1 or at col==IMAGE_WIDTH-1.
- col wraps to 0 at IMAGE_WIDTH-1, then row increments.
REQ-009 An accepted pixel is written into accumulator lane `lane`, bits [lane*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the least significant lane.
REQ-010 A word completes when the accepted pixel has lane==NUM_PE-1 or col==IMAGE_WIDTH-1.
- At that edge the accumulator (including the current pixel) is copied to OUT_DATA and out_valid is set.
- Lanes above the current lane are driven to zero.
- The accumulator is cleared to zero.
REQ-011 OUT_PUSH = out_valid && !OUT_FULL.
- out_valid clears after a push unless a new word completes on the same edge, in which case OUT_DATA reloads and out_valid stays 1.
REQ-012 Latency: the word appears on OUT_DATA, with OUT_PUSH high (if !OUT_FULL), in the cycle after the edge that accepted its last pixel.
REQ-013 Words per row = ceil(IMAGE_WIDTH/NUM_PE); words per frame = IMAGE_HEIGHT times that.
REQ-014 While OUT_FULL=1 and out_valid=1:
- OUT_DATA holds stable.
- No push occurs.
- No pixel is accepted.
- No data is lost or duplicated.
REQ-015 While IN_VALID=0, state and counters hold; an idle gap mid-word does not emit a partial word.

Reset
REQ-016 While RESET_N=0, immediately and independent of CLK:
- state=IDLE; lane, col, row, accumulator, OUT_DATA = 0; out_valid=0.
- IN_READY=0, OUT_PUSH=0, BUSY=0, DONE=0.
REQ-017 Reset mid-frame discards the partial word and any pending output word.
REQ-018 After RESET_N deasserts, the block waits in IDLE for a fresh START.

Verification
REQ-019 Nominal: START, then pixels 1..100 with IN_VALID=1 and OUT_FULL=0.
- Exactly 30 pushes.
- Words 0x04030201, 0x08070605, 0x00000A09, 0x0E0D0C0B, 0x1211100F, 0x00001413, ...
- Final word 0x00006463.
- DONE pulses once, one cycle after the final push.
REQ-020 Latency: pixel 4 accepted at edge k -> OUT_PUSH=1 with OUT_DATA=0x04030201 in cycle k+1.
REQ-021 Backpressure: hold OUT_FULL=1 for 5 cycles while word 0x08070605 is pending.
- IN_READY=0 and OUT_PUSH=0 throughout.
- OUT_DATA stable throughout.
- On release, one push of 0x08070605 and the stream resumes with no loss.
REQ-022 Gaps: random IN_VALID bubbles (random seed) -> push sequence identical to REQ-019.
REQ-023 Reset mid-frame: assert RESET_N=0 after pixel 15, then START and send 1..100 -> all outputs zero during reset, and the output is identical to REQ-019 with no stale word.
REQ-024 START ignored: START pulsed during RUN -> counters unaffected; output identical to REQ-019.
